// File: rtl/clk_byp_seq_if.sv
// clk_byp_seq_if: bypass request/ack bundle between requesters and clk_byp_seq.
// div_step_down_req_o exists only when CLK_BYP_SEQ_STEP_DOWN_EN is defined.
interface clk_byp_if;
    logic [3:0] io_byp_req_i;
    logic [3:0] all_byp_req_i;
    logic       ext_clk_stable_i;
    logic [3:0] io_byp_ack_o;
    logic [3:0] all_byp_ack_o;
    logic       sel_io_o;
    logic       sel_all_o;
    logic       busy_o;
    logic [1:0] err_o;
`ifdef CLK_BYP_SEQ_STEP_DOWN_EN
    logic [3:0] div_step_down_req_o;
    modport master (
        output io_byp_req_i, all_byp_req_i, ext_clk_stable_i,
        input  io_byp_ack_o, all_byp_ack_o, sel_io_o, sel_all_o, busy_o, err_o, div_step_down_req_o
    );
    modport slave (
        input  io_byp_req_i, all_byp_req_i, ext_clk_stable_i,
        output io_byp_ack_o, all_byp_ack_o, sel_io_o, sel_all_o, busy_o, err_o, div_step_down_req_o
    );
`else
    modport master (
        output io_byp_req_i, all_byp_req_i, ext_clk_stable_i,
        input  io_byp_ack_o, all_byp_ack_o, sel_io_o, sel_all_o, busy_o, err_o
    );
    modport slave (
        input  io_byp_req_i, all_byp_req_i, ext_clk_stable_i,
        output io_byp_ack_o, all_byp_ack_o, sel_io_o, sel_all_o, busy_o, err_o
    );
`endif
endinterface

// File: rtl/clk_byp_seq.sv
// clk_byp_seq: sequences io/all clock-bypass mux selects with stable wait, settle and mubi4 acks.
// Optional CLK_BYP_SEQ_STEP_DOWN_EN adds the mubi4 divider step-down request output.
module clk_byp_seq #(
    parameter int unsigned SettleCycles  = 16,
    parameter int unsigned StableTimeout = 255
) (
    input logic      clk_i,
    input logic      rst_i,
    clk_byp_if.slave bus
);
    localparam logic [3:0] MuTrue = 4'h6;
    localparam logic [3:0] MuFalse = 4'h9;
    localparam logic [7:0] SettleInit = 8'(SettleCycles - 1);
    localparam logic [7:0] TimeoutLast = 8'(StableTimeout - 1);
    typedef enum logic [1:0] {IDLE, DROP, WAIT_STABLE, SETTLE} state_e;
    typedef enum logic [1:0] {M_INT, M_IO, M_ALL} mode_e;
    state_e     state_q, state_d;
    mode_e      cur_q, cur_d, tgt_q, tgt_d, desired;
    logic [7:0] cnt_q, cnt_d;
    logic       lock_q, lock_d, sel_io_q, sel_io_d, sel_all_q, sel_all_d, busy_q, busy_d;
    logic [3:0] io_ack_q, io_ack_d, all_ack_q, all_ack_d;
    logic [1:0] err_q, err_d;
    logic       io_true, all_true, both_false, bad_enc, launch, to_ext, abort, done, all_ok, to_int;
    assign io_true = bus.io_byp_req_i == MuTrue;
    assign all_true = bus.all_byp_req_i == MuTrue;
    assign both_false = bus.io_byp_req_i == MuFalse && bus.all_byp_req_i == MuFalse;
    assign bad_enc = !(io_true || bus.io_byp_req_i == MuFalse) || !(all_true || bus.all_byp_req_i == MuFalse);
    assign desired = lock_q ? M_INT : all_true ? M_ALL : io_true ? M_IO : M_INT;
    assign launch = state_q == IDLE && desired != cur_q;
    assign to_ext = state_q == WAIT_STABLE && bus.ext_clk_stable_i;
    assign abort = state_q == WAIT_STABLE && !bus.ext_clk_stable_i && cnt_q == TimeoutLast;
    assign done = state_q == SETTLE && cnt_q == 8'd0;
    assign to_int = state_q == DROP && tgt_q == M_INT;
`ifdef CLK_BYP_SEQ_STEP_DOWN_EN
    logic [3:0] step_q;
    // ALL ack additionally waits for the divider step-down to have been requested
    assign all_ok = step_q == MuTrue;
    assign bus.div_step_down_req_o = step_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) step_q <= MuFalse;
        else step_q <= sel_all_d ? MuTrue : MuFalse;
    end
`else
    assign all_ok = 1'b1;
`endif
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cur_q     <= M_INT;
            tgt_q     <= M_INT;
            cnt_q     <= 8'd0;
            lock_q    <= 1'b0;
            sel_io_q  <= 1'b0;
            sel_all_q <= 1'b0;
            busy_q    <= 1'b0;
            io_ack_q  <= MuFalse;
            all_ack_q <= MuFalse;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            sel_io_q  <= sel_io_d;
            sel_all_q <= sel_all_d;
            busy_q    <= busy_d;
            io_ack_q  <= io_ack_d;
            all_ack_q <= all_ack_d;
            err_q     <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cur_d = cur_q;
        tgt_d = tgt_q;
        lock_d = lock_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (both_false) lock_d = 1'b0;
                if (launch) begin
                    state_d = DROP;
                    tgt_d = desired;
                end
            end
            DROP: begin
                state_d = to_int ? SETTLE : WAIT_STABLE;
                cnt_d = to_int ? SettleInit : 8'd0;
            end
            WAIT_STABLE: begin
                state_d = to_ext ? SETTLE : abort ? IDLE : WAIT_STABLE;
                cnt_d = to_ext ? SettleInit : abort ? 8'd0 : cnt_q + 8'd1;
                if (abort) begin
                    cur_d = M_INT;
                    lock_d = 1'b1;
                end
            end
            default: begin
                state_d = done ? IDLE : SETTLE;
                cnt_d = done ? 8'd0 : cnt_q - 8'd1;
                if (done) cur_d = tgt_q;
            end
        endcase
    end
    // selects move only on SETTLE entry or abort; acks drop on launch and rise on completion
    always_comb begin
        sel_io_d = (abort || to_int) ? 1'b0 : to_ext ? (tgt_q != M_INT) : sel_io_q;
        sel_all_d = (abort || to_int) ? 1'b0 : to_ext ? (tgt_q == M_ALL) : sel_all_q;
        io_ack_d = (launch || abort) ? MuFalse : done ? ((tgt_q != M_INT) ? MuTrue : MuFalse) : io_ack_q;
        all_ack_d = (launch || abort) ? MuFalse : done ? ((tgt_q == M_ALL && all_ok) ? MuTrue : MuFalse) : all_ack_q;
        busy_d = state_d != IDLE;
        err_d = err_q | {abort, bad_enc};
    end
    assign bus.sel_io_o = sel_io_q;
    assign bus.sel_all_o = sel_all_q;
    assign bus.busy_o = busy_q;
    assign bus.io_byp_ack_o = io_ack_q;
    assign bus.all_byp_ack_o = all_ack_q;
    assign bus.err_o = err_q;
endmodule

// File: tb/tb_clk_byp_seq.sv
// tb_clk_byp_seq: scoreboard bench for clk_byp_seq; predicts each completed switch from the
// mode rules and its exact completion edge, plus idle/mid-sequence snapshots.
module tb_clk_byp_seq;
    localparam int S = 16;
    localparam int T = 255;
    localparam logic [3:0] TR = 4'h6;
    localparam logic [3:0] FA = 4'h9;
    typedef struct {
        bit         busy;
        int         done;
        bit         sio;
        bit         sall;
        logic [3:0] ioa;
        logic [3:0] alla;
        logic [1:0] err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit smp = 1'b0;
    bit pb = 1'b0;
    exp_t qs[$];
    exp_t qm[$];
    exp_t me;
    int cur;
    bit lock;
    logic [1:0] merr;
    logic [3:0] r_io, r_al;
    int d2;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    clk_byp_if bus();
    clk_byp_seq #(.SettleCycles(S), .StableTimeout(T)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    task automatic cmp(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
        end
    endtask
    task automatic cmp_all(exp_t e, bit seq);
        cmp("sel_io", int'(bus.sel_io_o), int'(e.sio));
        cmp("sel_all", int'(bus.sel_all_o), int'(e.sall));
        cmp("io_ack", int'(bus.io_byp_ack_o), int'(e.ioa));
        cmp("all_ack", int'(bus.all_byp_ack_o), int'(e.alla));
        cmp("err", int'(bus.err_o), int'(e.err));
        cmp("busy", int'(bus.busy_o), int'(e.busy));
        if (seq) cmp("done_cycle", cyc, e.done);
    endtask
    function automatic exp_t mk(bit b, int done, int sm, int am, logic [1:0] e);
        exp_t x;
        x.busy = b;
        x.done = done;
        x.sio = sm != 0;
        x.sall = sm == 2;
        x.ioa = (am != 0) ? TR : FA;
        x.alla = (am == 2) ? TR : FA;
        x.err = e;
        return x;
    endfunction
    // modes: 0 = internal, 1 = io bypass, 2 = all bypass
    function automatic int want(logic [3:0] io, logic [3:0] al, bit lk);
        if (lk) return 0;
        if (al == TR) return 2;
        if (io == TR) return 1;
        return 0;
    endfunction
    function automatic int lat(int m);
        return ((m == 0) ? 1 : 2) + S;
    endfunction
    function automatic logic [3:0] pick(bit allow_bad);
        int r;
        r = $urandom_range(0, 9);
        return (r < 4) ? TR : (r < 8 || !allow_bad) ? FA : 4'($urandom);
    endfunction
    always @(negedge clk) begin
        if (smp) begin
            if (qm.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sample_queue_empty cyc=%0d", cyc);
            end else begin
                me = qm.pop_front();
                cmp_all(me, 1'b0);
            end
        end
        if (!rst && pb && !bus.busy_o) begin
            if (qs.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_switch cyc=%0d got=none exp=none", cyc);
            end else begin
                me = qs.pop_front();
                cmp_all(me, 1'b1);
            end
        end
`ifdef CLK_BYP_SEQ_STEP_DOWN_EN
        if (!rst) cmp("step_down", int'(bus.div_step_down_req_o), int'(bus.sel_all_o ? TR : FA));
`endif
        pb = bus.busy_o;
    end
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic sample(bit b, int sm, int am);
        qm.push_back(mk(b, 0, sm, am, merr));
        smp = 1'b1;
        @(negedge clk);
        #1 smp = 1'b0;
    endtask
    task automatic wait_empty(int n);
        for (int k = 0; k < n && (qs.size() != 0 || qm.size() != 0); k++) @(negedge clk);
        #1;
        checks++;
        if (qs.size() != 0 || qm.size() != 0) begin
            failures++;
            $display("FAIL wait_switch cyc=%0d got=pending exp=done", cyc);
            qs.delete();
            qm.delete();
        end
    endtask
    // called just after an edge; the next edge is E0
    task automatic issue(logic [3:0] io, logic [3:0] al, bit st);
        int d, e0;
        bus.io_byp_req_i = io;
        bus.all_byp_req_i = al;
        bus.ext_clk_stable_i = st;
        e0 = cyc + 1;
        if (!(io inside {TR, FA}) || !(al inside {TR, FA})) merr[0] = 1'b1;
        d = want(io, al, lock);
        if (lock && io == FA && al == FA) lock = 1'b0;
        if (d == cur) return;
        if (d != 0 && !st) begin
            merr[1] = 1'b1;
            lock = 1'b1;
            cur = 0;
            qs.push_back(mk(1'b0, e0 + 1 + T, 0, 0, merr));
        end else begin
            cur = d;
            qs.push_back(mk(1'b0, e0 + lat(d), d, d, merr));
        end
    endtask
    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench timed out");
    end
    initial begin
        bus.io_byp_req_i = FA;
        bus.all_byp_req_i = FA;
        bus.ext_clk_stable_i = 1'b1;
        cur = 0;
        lock = 1'b0;
        merr = 2'b00;
        tick(3);
        rst = 1'b0;
        sample(1'b0, 0, 0);
        tick(20);
        sample(1'b0, 0, 0);
        tick(1);
        issue(TR, FA, 1'b1);
        tick(2);
        sample(1'b1, 0, 0);
        tick(1);
        sample(1'b1, 1, 0);
        wait_empty(40);
        tick(1);
        issue(TR, TR, 1'b1);
        tick(1);
        sample(1'b1, 1, 0);
        tick(1);
        sample(1'b1, 1, 0);
        tick(1);
        sample(1'b1, 2, 0);
        wait_empty(40);
        tick(1);
        issue(TR, FA, 1'b1);
        wait_empty(40);
        tick(1);
        issue(FA, FA, 1'b1);
        wait_empty(40);
        tick(1);
        issue(TR, FA, 1'b0);
        wait_empty(300);
        tick(1);
        sample(1'b0, 0, 0);
        tick(1);
        issue(FA, TR, 1'b1);
        tick(20);
        sample(1'b0, 0, 0);
        tick(1);
        issue(FA, FA, 1'b1);
        tick(3);
        issue(TR, FA, 1'b1);
        wait_empty(40);
        tick(1);
        issue(FA, FA, 1'b1);
        wait_empty(40);
        tick(1);
        issue(4'h3, FA, 1'b1);
        tick(2);
        sample(1'b0, 0, 0);
        tick(1);
        issue(TR, FA, 1'b1);
        tick(9);
        #1 rst = 1'b1;
        qs.delete();
        cur = 0;
        lock = 1'b0;
        merr = 2'b00;
        sample(1'b0, 0, 0);
        bus.io_byp_req_i = FA;
        bus.all_byp_req_i = FA;
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 30; i++) begin
            r_io = pick(1'b1);
            r_al = pick(1'b1);
            issue(r_io, r_al, 1'b1);
            if (qs.size() != 0 && $urandom_range(0, 2) == 0) begin
                tick(3);
                r_io = pick(1'b0);
                r_al = pick(1'b0);
                bus.io_byp_req_i = r_io;
                bus.all_byp_req_i = r_al;
                d2 = want(r_io, r_al, lock);
                if (d2 != cur) begin
                    qs.push_back(mk(1'b0, qs[$].done + 1 + lat(d2), d2, d2, merr));
                    cur = d2;
                end
            end
            if (qs.size() == 0) begin
                tick(2);
                sample(1'b0, cur, cur);
            end
            wait_empty(100);
            tick(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
